// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encodings, FSM states and flag bit positions shared by
//               the sequential ALU and its multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation select encodings; 12..15 are reserved and produce zero
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    // Controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bit positions inside the packed flag register
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

endpackage
`default_nettype wire

// File: rtl/shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mul
// Description : Iterative shift-add multiplier. One multiplier bit is retired
//               per clock; done is asserted during the final iteration and
//               product already includes that iteration's partial sum.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [SHW-1:0] c_last = SHW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   count_q;
    logic             busy_q;
    logic [WIDTH-1:0] acc_d;

    // Partial sum for the current iteration
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign done    = busy_q && (count_q == c_last);
    assign product = acc_d;

    // Operand latch on start, then one shift-add step per cycle while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + SHW'(1);
            if (count_q == c_last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Handshaked ALU with registered result/flags. Single-cycle
//               arithmetic, logic and shift ops; multi-cycle multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    state_t              state_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    result_q;
    logic [FLAG_W-1:0]   flags_q;

    logic                accept_w;
    logic                mul_start_w;
    logic                mul_done_w;
    logic [WIDTH-1:0]    mul_product_w;
    logic [FLAG_W-1:0]   mul_flags_w;

    logic [WIDTH-1:0]    b_op_w;
    logic                carry_w;
    logic [WIDTH:0]      sum_w;
    logic [SHW-1:0]      shamt_w;
    logic [WIDTH-1:0]    op_res_d;
    logic [FLAG_W-1:0]   op_flags_d;

    assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_w    = in_valid && in_ready;
    assign mul_start_w = accept_w && (opcode == OP_MUL);

    assign shamt_w = b[SHW-1:0];
    assign b_op_w  = (opcode == OP_SUB) ? ~b : b;
    assign carry_w = (opcode == OP_SUB) ? 1'b1 : ((opcode == OP_ADD) ? cin : 1'b0);
    assign sum_w   = {1'b0, a} + {1'b0, b_op_w} + {{WIDTH{1'b0}}, carry_w};

    // Single-cycle operation unit: result plus all four flags
    always_comb begin
        op_res_d   = '0;
        op_flags_d = '0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                op_res_d           = sum_w[WIDTH-1:0];
                op_flags_d[FLAG_C] = sum_w[WIDTH];
                op_flags_d[FLAG_V] = (a[WIDTH-1] == b_op_w[WIDTH-1]) &&
                                     (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  op_res_d = a & b;
            OP_OR:   op_res_d = a | b;
            OP_XOR:  op_res_d = a ^ b;
            OP_NOR:  op_res_d = ~(a | b);
            OP_SLL:  op_res_d = a << shamt_w;
            OP_SRL:  op_res_d = a >> shamt_w;
            OP_SRA:  op_res_d = $signed(a) >>> shamt_w;
            OP_SLT:  op_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: op_res_d = {{(WIDTH-1){1'b0}}, (a < b)};
            default: op_res_d = '0;
        endcase
        op_flags_d[FLAG_Z] = (op_res_d == '0);
        op_flags_d[FLAG_N] = op_res_d[WIDTH-1];
    end

    // Multiply completion flags: only z and n are meaningful
    always_comb begin
        mul_flags_w         = '0;
        mul_flags_w[FLAG_Z] = (mul_product_w == '0);
        mul_flags_w[FLAG_N] = mul_product_w[WIDTH-1];
    end

    shift_add_mul #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_w),
        .a       (a),
        .b       (b),
        .done    (mul_done_w),
        .product (mul_product_w)
    );

    // Controller and output registers; a fresh load wins over the consume-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            out_valid_q        <= 1'b0;
            result_q           <= '0;
            flags_q            <= '0;
            flags_q[FLAG_Z]    <= 1'b1;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_w) begin
                        if (opcode == OP_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            result_q    <= op_res_d;
                            flags_q     <= op_flags_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done_w) begin
                        result_q    <= mul_product_w;
                        flags_q     <= mul_flags_w;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flags_q[FLAG_Z];
    assign flag_n    = flags_q[FLAG_N];
    assign flag_c    = flags_q[FLAG_C];
    assign flag_v    = flags_q[FLAG_V];

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH=32): vector table
//               through a scoreboard plus multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         z, n, c, v;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z, n, c, v;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vcin, input logic [W-1:0] res, input logic c, input logic v);
        vec_t t;
        t.op = op; t.a = va; t.b = vb; t.cin = vcin; t.res = res;
        t.z = (res == '0); t.n = res[W-1]; t.c = c; t.v = v;
        return t;
    endfunction

    function automatic exp_t to_exp(input vec_t t);
        exp_t e;
        e.res = t.res; e.z = t.z; e.n = t.n; e.c = t.c; e.v = t.v;
        return e;
    endfunction

    // Scoreboard: compare every consumed result against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with no pending expectation", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("scoreboard", {28'd0, result, flag_z, flag_n, flag_c, flag_v},
                      {28'd0, e.res, e.z, e.n, e.c, e.v});
            end
        end
    end

    // Present one op (caller is at posedge+1), wait bounded for acceptance
    task automatic issue(input vec_t t, input bit push);
        int n;
        opcode = t.op; a = t.a; b = t.b; cin = t.cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 64'(n), 64'd0);
        end
        if (push) sb.push_back(to_exp(t));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    vec_t vec[19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        int   lat;
        bit   ok;

        vec[0]  = mk(4'd0,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        vec[1]  = mk(4'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        vec[2]  = mk(4'd0,  32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0);
        vec[3]  = mk(4'd0,  32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1);
        vec[4]  = mk(4'd1,  32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0);
        vec[5]  = mk(4'd1,  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        vec[6]  = mk(4'd1,  32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        vec[7]  = mk(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0);
        vec[8]  = mk(4'd3,  32'h0F0F0000, 32'h000000F0, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0);
        vec[9]  = mk(4'd4,  32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 32'h00000000, 1'b0, 1'b0);
        vec[10] = mk(4'd5,  32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        vec[11] = mk(4'd6,  32'h00000001, 32'h00000021, 1'b0, 32'h00000002, 1'b0, 1'b0);
        vec[12] = mk(4'd7,  32'h80000000, 32'h00000004, 1'b0, 32'h08000000, 1'b0, 1'b0);
        vec[13] = mk(4'd8,  32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 1'b0, 1'b0);
        vec[14] = mk(4'd9,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0);
        vec[15] = mk(4'd10, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0);
        vec[16] = mk(4'd11, 32'h00010003, 32'h00000005, 1'b0, 32'h0005000F, 1'b0, 1'b0);
        vec[17] = mk(4'd12, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 1'b0);
        vec[18] = mk(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b0, 1'b0);

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; opcode = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {58'd0, out_valid, in_ready, flag_z, flag_n, flag_c, flag_v},
              {58'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_result", 64'(result), 64'd0);
        rst = 1'b0;

        // Table sweep, back-to-back with the consumer always ready
        for (int i = 0; i < 19; i++) begin
            issue(vec[i], 1'b1);
        end
        drain();

        // Single-cycle latency, then multiply latency and stall
        issue(vec[0], 1'b1);
        check("add_latency", 64'(out_valid), 64'd1);
        drain();
        issue(vec[16], 1'b1);
        lat = 0; ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd32);
        check("mul_in_ready_low", 64'(ok), 64'd1);
        drain();

        // Backpressure: second ADD waits until the first result is taken
        out_ready = 1'b0;
        issue(mk(4'd0, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0), 1'b1);
        t = mk(4'd0, 32'd100, 32'd1, 1'b0, 32'd101, 1'b0, 1'b0);
        opcode = t.op; a = t.a; b = t.b; cin = t.cin; in_valid = 1'b1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!(out_valid && !in_ready && result == 32'd30)) ok = 1'b0;
        end
        check("bp_hold", 64'(ok), 64'd1);
        sb.push_back(to_exp(t));
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd101});
        drain();

        // MUL with held output, then an ADD waiting behind it
        out_ready = 1'b0;
        issue(vec[16], 1'b1);
        t = mk(4'd0, 32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 1'b0);
        opcode = t.op; a = t.a; b = t.b; cin = t.cin; in_valid = 1'b1;
        lat = 0; ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        repeat (3) begin
            if (in_ready || result != 32'h0005000F) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("mul_then_add_stall", {32'(lat), 31'd0, ok}, {32'd32, 31'd0, 1'b1});
        sb.push_back(to_exp(t));
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul_then_add_result", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd15});
        drain();

        // Reset in the middle of a multiply discards it
        issue(vec[16], 1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_mul_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_mul_reset", {27'd0, out_valid, in_ready, flag_z, result},
              {27'd0, 1'b0, 1'b1, 1'b1, 32'd0});
        issue(mk(4'd0, 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0), 1'b1);
        drain();
        repeat (40) begin
            @(posedge clk);
        end
        #1;
        check("no_stale_mul", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
